dma_write_master: RTL and testbench
===================================

DMA_WRITE_MASTER -- requirements
Module: dma_write_master

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports: cmd_valid_i  in  1 / cmd_ready_o  out  1  descriptor command handshake.
REQ-004 SHALL have ports: cmd_dst_addr_i  in  32  destination byte address; cmd_length_i  in  16  byte count; cmd_desc_idx_i  in  8  descriptor index; cmd_last_i  in  1  last descriptor of chain.
REQ-005 SHALL have ports: data_valid_i  in  1 / data_i  in  32 / data_ready_o  out  1  write-data stream, little-endian.
REQ-006 SHALL have ports: avm_write_o  out  1 / avm_address_o  out  32 / avm_writedata_o  out  32 / avm_byteenable_o  out  4 / avm_waitrequest_i  in  1  Avalon-MM write master.
REQ-007 SHALL have ports: dma_status_fifo_wr_req_o  out  1 / dma_status_fifo_data_o  out  25 / dma_status_fifo_almost_full_i  in  1  status push to status-update stage.
REQ-008 SHALL have ports: busy_o  out  1  high in any state except IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, WRITE, STATUS.
REQ-010 IDLE: cmd_ready_o SHALL be 1 iff dma_status_fifo_almost_full_i = 0; command accepted when cmd_valid_i & cmd_ready_o.
REQ-011 On accept SHALL latch addr = {cmd_dst_addr_i[31:2], 2'b00}, remaining = cmd_length_i, idx, last; bytes counter cleared to 0.
REQ-012 On accept with cmd_length_i = 0 SHALL go to STATUS; otherwise to WRITE.
REQ-013 WRITE: avm_write_o = data_valid_i; avm_writedata_o = data_i; avm_address_o = latched addr; data_ready_o = data_valid_i & ~avm_waitrequest_i.
REQ-014 A beat completes when avm_write_o & ~avm_waitrequest_i; on completion addr += 4 (32-bit wrap), remaining -= min(remaining,4), bytes += min(remaining,4).
REQ-015 avm_byteenable_o SHALL be 4'b1111 when remaining >= 4, else 4'b0001/0011/0111 for remaining = 1/2/3.
REQ-016 Upstream SHALL hold data_i stable while data_valid_i & ~data_ready_o; block relies on this for Avalon stability.
REQ-017 Beat completing with remaining <= 4 SHALL transition to STATUS next cycle; no further beats issued.
REQ-018 STATUS: dma_status_fifo_wr_req_o SHALL pulse exactly one cycle with data = {last, idx[7:0], bytes[15:0]}, then IDLE.
REQ-019 Status word bit 24 SHALL be last, bits 23:16 idx, bits 15:0 byte count equal to cmd_length_i.
REQ-020 Latency: accept -> first avm_write_o opportunity 1 cycle; last beat -> status push 1 cycle; STATUS -> cmd_ready_o 1 cycle.
REQ-021 almost_full asserting during WRITE/STATUS SHALL NOT stall the command in flight (FIFO slack covers it).
REQ-022 Outside WRITE, avm_write_o and data_ready_o SHALL be 0; outside STATUS, dma_status_fifo_wr_req_o SHALL be 0.
REQ-023 Max length 65535 SHALL complete in 16384 beats with correct final byteenable 4'b0111.

Reset
REQ-024 reset = 0 at a rising edge SHALL force IDLE, addr/remaining/bytes/idx/last = 0.
REQ-025 During and after reset all outputs SHALL be 0 except cmd_ready_o (follows REQ-010 once reset = 1).
REQ-026 Reset mid-WRITE or mid-STATUS SHALL abandon the command; no status word emitted for it.

Structure
REQ-027 Shared package dma_pkg SHALL hold state encodings, status field constants (LAST_BIT=24, IDX_MSB/LSB=23/16, BYTES_MSB/LSB=15/0, STATUS_W=25) and byteenable function.
REQ-028 Single module, no sub-module; byteenable decode via package function.

Verification
REQ-029 cmd addr 0x1000, len 8, idx 3, last 0, no waitrequest -> writes 0x1000,0x1004 BE 1111; status 0x003_0008 (bit24=0).
REQ-030 len 6, addr 0x2002, last 1, idx 0x7F -> writes 0x2000 BE 1111, 0x2004 BE 0011; status {1,0x7F,0x0006}.
REQ-031 waitrequest held 3 cycles on beat 2 of 4 -> address/data/BE stable during stall, exactly 4 completed beats, one status pulse.
REQ-032 len 0, idx 5 -> no avm_write_o; status {last,0x05,0x0000} 1 cycle after accept.
REQ-033 almost_full = 1 in IDLE -> cmd_ready_o = 0, command held; deassert -> accepted next cycle.
REQ-034 reset = 0 after 2 of 4 beats -> IDLE, no status push; next command runs normally from its own address.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA write path: FSM encoding, status word layout
// and the tail-beat byteenable decode.
package dma_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWrite  = 2'd1,
        StStatus = 2'd2
    } dma_state_e;

    localparam int unsigned STATUS_W  = 25;
    localparam int unsigned LAST_BIT  = 24;
    localparam int unsigned IDX_MSB   = 23;
    localparam int unsigned IDX_LSB   = 16;
    localparam int unsigned BYTES_MSB = 15;
    localparam int unsigned BYTES_LSB = 0;

    // Full word while at least 4 bytes remain, else the low bytes of a short tail.
    function automatic logic [3:0] byteenable(input logic [15:0] remaining);
        logic [3:0] be;
        if (remaining >= 16'd4) begin
            be = 4'b1111;
        end else begin
            case (remaining[1:0])
                2'd1:    be = 4'b0001;
                2'd2:    be = 4'b0011;
                2'd3:    be = 4'b0111;
                default: be = 4'b0000;
            endcase
        end
        return be;
    endfunction

endpackage

// File: rtl/dma_write_master.sv
// Descriptor-driven Avalon-MM write master: streams one command's data to memory
// as 32-bit beats, then pushes a single status word for it.
module dma_write_master
    import dma_pkg::*;
(
    input  logic                clk,
    input  logic                reset,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [31:0]         cmd_dst_addr_i,
    input  logic [15:0]         cmd_length_i,
    input  logic [7:0]          cmd_desc_idx_i,
    input  logic                cmd_last_i,

    input  logic                data_valid_i,
    input  logic [31:0]         data_i,
    output logic                data_ready_o,

    output logic                avm_write_o,
    output logic [31:0]         avm_address_o,
    output logic [31:0]         avm_writedata_o,
    output logic [3:0]          avm_byteenable_o,
    input  logic                avm_waitrequest_i,

    output logic                dma_status_fifo_wr_req_o,
    output logic [STATUS_W-1:0] dma_status_fifo_data_o,
    input  logic                dma_status_fifo_almost_full_i,

    output logic                busy_o
);

    dma_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] bytes_q, bytes_d;
    logic [7:0]  idx_q, idx_d;
    logic        last_q, last_d;

    logic        cmd_accept;
    logic        beat_done;
    logic [15:0] step;
    logic [STATUS_W-1:0] status_word;

    assign step = (remaining_q >= 16'd4) ? 16'd4 : remaining_q;

    always_comb begin
        status_word                      = '0;
        status_word[LAST_BIT]            = last_q;
        status_word[IDX_MSB:IDX_LSB]     = idx_q;
        status_word[BYTES_MSB:BYTES_LSB] = bytes_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            bytes_q     <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            bytes_q     <= bytes_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        state_d                  = state_q;
        addr_d                   = addr_q;
        remaining_d              = remaining_q;
        bytes_d                  = bytes_q;
        idx_d                    = idx_q;
        last_d                   = last_q;
        cmd_accept               = 1'b0;
        beat_done                = 1'b0;
        cmd_ready_o              = 1'b0;
        data_ready_o             = 1'b0;
        avm_write_o              = 1'b0;
        avm_address_o            = '0;
        avm_writedata_o          = '0;
        avm_byteenable_o         = '0;
        dma_status_fifo_wr_req_o = 1'b0;
        dma_status_fifo_data_o   = '0;
        busy_o                   = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                cmd_ready_o = ~dma_status_fifo_almost_full_i;
                cmd_accept  = cmd_valid_i & cmd_ready_o;
                if (cmd_accept) begin
                    addr_d      = {cmd_dst_addr_i[31:2], 2'b00};
                    remaining_d = cmd_length_i;
                    bytes_d     = '0;
                    idx_d       = cmd_desc_idx_i;
                    last_d      = cmd_last_i;
                    state_d     = (cmd_length_i == 16'd0) ? StStatus : StWrite;
                end
            end
            StWrite: begin
                avm_write_o      = data_valid_i;
                avm_address_o    = addr_q;
                avm_writedata_o  = data_i;
                avm_byteenable_o = byteenable(remaining_q);
                data_ready_o     = data_valid_i & ~avm_waitrequest_i;
                beat_done        = avm_write_o & ~avm_waitrequest_i;
                if (beat_done) begin
                    addr_d      = addr_q + 32'd4;
                    remaining_d = remaining_q - step;
                    bytes_d     = bytes_q + step;
                    if (remaining_q <= 16'd4) begin
                        state_d = StStatus;
                    end
                end
            end
            StStatus: begin
                dma_status_fifo_wr_req_o = 1'b1;
                dma_status_fifo_data_o   = status_word;
                state_d                  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Hold every output quiet while reset is asserted, even before the edge lands.
        if (!reset) begin
            cmd_ready_o              = 1'b0;
            data_ready_o             = 1'b0;
            avm_write_o              = 1'b0;
            avm_address_o            = '0;
            avm_writedata_o          = '0;
            avm_byteenable_o         = '0;
            dma_status_fifo_wr_req_o = 1'b0;
            dma_status_fifo_data_o   = '0;
            busy_o                   = 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_write_master.sv
// Directed bench for dma_write_master: inputs change on the falling edge and
// outputs are sampled shortly after it.
module tb_dma_write_master;
    import dma_pkg::*;

    logic                clk;
    logic                reset;
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [31:0]         cmd_dst_addr_i;
    logic [15:0]         cmd_length_i;
    logic [7:0]          cmd_desc_idx_i;
    logic                cmd_last_i;
    logic                data_valid_i;
    logic [31:0]         data_i;
    logic                data_ready_o;
    logic                avm_write_o;
    logic [31:0]         avm_address_o;
    logic [31:0]         avm_writedata_o;
    logic [3:0]          avm_byteenable_o;
    logic                avm_waitrequest_i;
    logic                dma_status_fifo_wr_req_o;
    logic [STATUS_W-1:0] dma_status_fifo_data_o;
    logic                dma_status_fifo_almost_full_i;
    logic                busy_o;

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int status_cnt = 0;

    dma_write_master u_dut (
        .clk                           (clk),
        .reset                         (reset),
        .cmd_valid_i                   (cmd_valid_i),
        .cmd_ready_o                   (cmd_ready_o),
        .cmd_dst_addr_i                (cmd_dst_addr_i),
        .cmd_length_i                  (cmd_length_i),
        .cmd_desc_idx_i                (cmd_desc_idx_i),
        .cmd_last_i                    (cmd_last_i),
        .data_valid_i                  (data_valid_i),
        .data_i                        (data_i),
        .data_ready_o                  (data_ready_o),
        .avm_write_o                   (avm_write_o),
        .avm_address_o                 (avm_address_o),
        .avm_writedata_o               (avm_writedata_o),
        .avm_byteenable_o              (avm_byteenable_o),
        .avm_waitrequest_i             (avm_waitrequest_i),
        .dma_status_fifo_wr_req_o      (dma_status_fifo_wr_req_o),
        .dma_status_fifo_data_o        (dma_status_fifo_data_o),
        .dma_status_fifo_almost_full_i (dma_status_fifo_almost_full_i),
        .busy_o                        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed Avalon beats and status pushes seen at each rising edge.
    always @(posedge clk) begin
        if (avm_write_o && !avm_waitrequest_i) beat_cnt <= beat_cnt + 1;
        if (dma_status_fifo_wr_req_o) status_cnt <= status_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a command and wait (bounded) for acceptance; returns at a falling edge.
    task automatic issue_cmd(input logic [31:0] a, input logic [15:0] len,
                             input logic [7:0] idx, input logic last);
        int n;
        @(negedge clk);
        cmd_valid_i    = 1'b1;
        cmd_dst_addr_i = a;
        cmd_length_i   = len;
        cmd_desc_idx_i = idx;
        cmd_last_i     = last;
        #1;
        n = 0;
        while (!cmd_ready_o && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    // One data beat, optionally stalled by waitrequest; starts and ends at a falling edge.
    task automatic beat(input logic [31:0] d, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input int stall);
        data_valid_i      = 1'b1;
        data_i            = d;
        avm_waitrequest_i = (stall > 0);
        #1;
        check_val("avm_write", {31'd0, avm_write_o}, 32'd1);
        check_val("avm_addr", avm_address_o, exp_addr);
        check_val("avm_be", {28'd0, avm_byteenable_o}, {28'd0, exp_be});
        check_val("avm_data", avm_writedata_o, d);
        for (int s = 0; s < stall; s++) begin
            check_val("stall_ready", {31'd0, data_ready_o}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            if (s == stall - 1) avm_waitrequest_i = 1'b0;
            #1;
            check_val("stall_addr", avm_address_o, exp_addr);
            check_val("stall_be", {28'd0, avm_byteenable_o}, {28'd0, exp_be});
            check_val("stall_data", avm_writedata_o, d);
        end
        check_val("data_ready", {31'd0, data_ready_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        data_valid_i = 1'b0;
    endtask

    // Expect the status pulse now and idle one cycle later.
    task automatic expect_status(input logic [31:0] exp);
        #1;
        check_val("st_wr_req", {31'd0, dma_status_fifo_wr_req_o}, 32'd1);
        check_val("st_data", {7'd0, dma_status_fifo_data_o}, exp);
        check_val("st_no_write", {31'd0, avm_write_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_val("st_one_pulse", {31'd0, dma_status_fifo_wr_req_o}, 32'd0);
        check_val("idle_busy", {31'd0, busy_o}, 32'd0);
        check_val("idle_ready", {31'd0, cmd_ready_o}, {31'd0, ~dma_status_fifo_almost_full_i});
    endtask

    int b0;
    int s0;
    logic [31:0] base;

    initial begin
        reset = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_dst_addr_i = '0;
        cmd_length_i = '0;
        cmd_desc_idx_i = '0;
        cmd_last_i = 1'b0;
        data_valid_i = 1'b0;
        data_i = '0;
        avm_waitrequest_i = 1'b0;
        dma_status_fifo_almost_full_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        check_val("rst_busy", {31'd0, busy_o}, 32'd0);
        check_val("rst_write", {31'd0, avm_write_o}, 32'd0);
        check_val("rst_wr_req", {31'd0, dma_status_fifo_wr_req_o}, 32'd0);
        check_val("rst_addr", avm_address_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("post_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        check_val("post_rst_data_rdy", {31'd0, data_ready_o}, 32'd0);

        // Aligned 8-byte transfer
        b0 = beat_cnt; s0 = status_cnt;
        issue_cmd(32'h0000_1000, 16'd8, 8'd3, 1'b0);
        #1;
        check_val("t1_busy", {31'd0, busy_o}, 32'd1);
        check_val("t1_no_valid", {31'd0, avm_write_o}, 32'd0);
        beat(32'hA0A0_0001, 32'h0000_1000, 4'b1111, 0);
        beat(32'hA0A0_0002, 32'h0000_1004, 4'b1111, 0);
        expect_status(32'h0003_0008);
        check_val("t1_beats", beat_cnt - b0, 32'd2);
        check_val("t1_status", status_cnt - s0, 32'd1);

        // Unaligned address, 6 bytes, partial tail
        b0 = beat_cnt;
        issue_cmd(32'h0000_2002, 16'd6, 8'h7F, 1'b1);
        beat(32'h1111_2222, 32'h0000_2000, 4'b1111, 0);
        beat(32'h3333_4444, 32'h0000_2004, 4'b0011, 0);
        expect_status(32'h017F_0006);
        check_val("t2_beats", beat_cnt - b0, 32'd2);

        // Waitrequest stall on beat 2 of 4
        b0 = beat_cnt; s0 = status_cnt;
        issue_cmd(32'h0000_3000, 16'd16, 8'd1, 1'b0);
        beat(32'hC000_0000, 32'h0000_3000, 4'b1111, 0);
        beat(32'hC000_0001, 32'h0000_3004, 4'b1111, 3);
        beat(32'hC000_0002, 32'h0000_3008, 4'b1111, 0);
        beat(32'hC000_0003, 32'h0000_300C, 4'b1111, 0);
        expect_status(32'h0001_0010);
        check_val("t3_beats", beat_cnt - b0, 32'd4);
        check_val("t3_status", status_cnt - s0, 32'd1);

        // Zero length: straight to status, no writes even with data offered
        b0 = beat_cnt;
        issue_cmd(32'h0000_0040, 16'd0, 8'd5, 1'b1);
        data_valid_i = 1'b1;
        #1;
        check_val("t4_data_ready", {31'd0, data_ready_o}, 32'd0);
        expect_status(32'h0105_0000);
        data_valid_i = 1'b0;
        check_val("t4_beats", beat_cnt - b0, 32'd0);

        // Three-byte transfer
        issue_cmd(32'h0000_5000, 16'd3, 8'd2, 1'b0);
        beat(32'h00AB_CDEF, 32'h0000_5000, 4'b0111, 0);
        expect_status(32'h0002_0003);

        // almost_full holds off acceptance, then does not stall the command in flight
        @(negedge clk);
        dma_status_fifo_almost_full_i = 1'b1;
        cmd_valid_i    = 1'b1;
        cmd_dst_addr_i = 32'h0000_4000;
        cmd_length_i   = 16'd4;
        cmd_desc_idx_i = 8'd9;
        cmd_last_i     = 1'b0;
        #1;
        check_val("af_ready", {31'd0, cmd_ready_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_val("af_held", {31'd0, busy_o}, 32'd0);
        dma_status_fifo_almost_full_i = 1'b0;
        #1;
        check_val("af_release", {31'd0, cmd_ready_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        dma_status_fifo_almost_full_i = 1'b1;
        #1;
        check_val("af_accepted", {31'd0, busy_o}, 32'd1);
        beat(32'h5555_AAAA, 32'h0000_4000, 4'b1111, 0);
        expect_status(32'h0009_0004);
        dma_status_fifo_almost_full_i = 1'b0;

        // Reset mid-write abandons the command
        s0 = status_cnt;
        issue_cmd(32'h0000_6000, 16'd16, 8'd4, 1'b1);
        beat(32'h6000_0000, 32'h0000_6000, 4'b1111, 0);
        beat(32'h6000_0001, 32'h0000_6004, 4'b1111, 0);
        reset = 1'b0;
        data_valid_i = 1'b1;
        #1;
        check_val("mid_rst_write", {31'd0, avm_write_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        data_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check_val("mid_rst_no_status", status_cnt - s0, 32'd0);
        issue_cmd(32'h0000_7000, 16'd4, 8'd6, 1'b0);
        beat(32'h7777_7777, 32'h0000_7000, 4'b1111, 0);
        expect_status(32'h0006_0004);

        // Maximum length with address wrap
        b0 = beat_cnt;
        base = 32'hFFFF_FF00;
        issue_cmd(base, 16'hFFFF, 8'hAA, 1'b0);
        for (int i = 0; i < 16384; i++) begin
            beat(32'(i), base + 32'(i * 4), (i == 16383) ? 4'b0111 : 4'b1111, 0);
        end
        expect_status(32'h00AA_FFFF);
        check_val("max_beats", beat_cnt - b0, 32'd16384);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
